// File: rtl/hc4s_core.sv
// ----------------------------------------------------------------------------
// hc4s_core
//   Parametrised HC4-series CPU core: 8-bit instruction, push-down stack of
//   STACK_DEPTH levels, ALU with carry/zero flags and a PC, sequenced by a
//   two-state FETCH/EXEC machine. Instruction fetch and RAM accesses use
//   ready/valid handshakes, so slow memories need no clock prescaling.
//
//   Optional feature macro: HC4S_ZFLAG_EN
//     defined   -> zero flag register, zero_out, JZ/JNZ conditional jumps
//     undefined -> no zero flag, zero_out tied 0, JZ/JNZ behave as NOP
//
// Parameters
//   DATA_W       stack/ALU/RAM data width (>=4)
//   STACK_DEPTH  stack levels (>=2); level0 = A, level1 = B
//   PC_W         program counter width
//
// Ports
//   clock        in   system clock
//   nReset       in   asynchronous active-low reset
//   instr_req    out  high in FETCH: pc_out valid, instruction wanted
//   instr_valid  in   instruction present (sampled in FETCH)
//   instruction  in   opcode byte
//   pc_out       out  current PC
//   ram_addr     out  RAM address = ir[3:0]
//   ram_wdata    out  ALU result during EXEC of an ALU op, else 0
//   ram_rdata    in   RAM read data (sampled when ram_ready in EXEC)
//   nRAM_RD      out  active-low read strobe
//   nRAM_WR      out  active-low write strobe
//   ram_ready    in   RAM access completes this cycle
//   stackA_out   out  stack level0
//   stackB_out   out  stack level1
//   carry_out    out  carry flag
//   zero_out     out  zero flag (0 when HC4S_ZFLAG_EN undefined)
// ----------------------------------------------------------------------------
module hc4s_core #(
    parameter int DATA_W      = 4,
    parameter int STACK_DEPTH = 4,
    parameter int PC_W        = 8
) (
    input  logic              clock,
    input  logic              nReset,
    output logic              instr_req,
    input  logic              instr_valid,
    input  logic [7:0]        instruction,
    output logic [PC_W-1:0]   pc_out,
    output logic [3:0]        ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              nRAM_RD,
    output logic              nRAM_WR,
    input  logic              ram_ready,
    output logic [DATA_W-1:0] stackA_out,
    output logic [DATA_W-1:0] stackB_out,
    output logic              carry_out,
    output logic              zero_out
);

    typedef enum logic {
        S_FETCH = 1'b0,
        S_EXEC  = 1'b1
    } state_t;

    state_t            state, state_next;
    logic [7:0]        ir;
    logic [PC_W-1:0]   pc;
    logic [DATA_W-1:0] stack [STACK_DEPTH];
    logic              carry;

    logic              is_alu, is_ld_mem, is_ld_imm, is_jump, mem_op;
    logic              exec_done;
    logic [DATA_W:0]   alu_full;
    logic [DATA_W-1:0] alu_result;
    logic              alu_sets_carry;
    logic              jump_taken;
    logic [PC_W-1:0]   pc_next;
    logic              push_en;
    logic [DATA_W-1:0] push_data;
    logic [2*DATA_W-1:0] jump_tgt;

    // ALU: returns {carry_out, result}. SUB is A + ~B + 1 so carry means no-borrow.
    function automatic logic [DATA_W:0] alu(input logic [2:0] op,
                                            input logic [DATA_W-1:0] a,
                                            input logic [DATA_W-1:0] b);
        logic [DATA_W:0] r;
        case (op)
            3'd0:    r = {1'b0, a};
            3'd1:    r = {1'b0, a & b};
            3'd2:    r = {1'b0, a} + {1'b0, ~b} + {{DATA_W{1'b0}}, 1'b1};
            3'd3:    r = {1'b0, a} + {1'b0, b};
            3'd4:    r = {1'b0, a | b};
            3'd5:    r = {1'b0, a ^ b};
            3'd6:    r = {1'b0, ~a};
            default: r = {1'b0, a[DATA_W-2:0], 1'b0};
        endcase
        return r;
    endfunction

    // Instruction decode
    assign is_alu    = ~ir[7];
    assign is_ld_mem = (ir[7:5] == 3'b100);
    assign is_ld_imm = (ir[7:5] == 3'b101);
    assign is_jump   = (ir[7:5] == 3'b111);
    assign mem_op    = is_alu | is_ld_mem;

    assign alu_full       = alu(ir[6:4], stack[0], stack[1]);
    assign alu_result     = alu_full[DATA_W-1:0];
    assign alu_sets_carry = is_alu & (ir[6:5] == 2'b01);

`ifdef HC4S_ZFLAG_EN
    logic zero_flg;
    assign zero_out = zero_flg;
`else
    assign zero_out = 1'b0;
`endif

    always_comb begin
        jump_taken = 1'b0;
        if (is_jump) begin
            case (ir[2:0])
                3'b000:  jump_taken = 1'b1;
                3'b010:  jump_taken = carry;
                3'b011:  jump_taken = ~carry;
`ifdef HC4S_ZFLAG_EN
                3'b100:  jump_taken = zero_flg;
                3'b101:  jump_taken = ~zero_flg;
`endif
                default: jump_taken = 1'b0;
            endcase
        end
    end

    // Jump target {B,A}, truncated or zero-extended to the PC width
    assign jump_tgt = {stack[1], stack[0]};
    assign pc_next  = jump_taken ? PC_W'(jump_tgt) : pc + PC_W'(1);

    assign push_en   = is_ld_mem | is_ld_imm;
    assign push_data = is_ld_mem ? ram_rdata : DATA_W'(ir[3:0]);

    // FSM state register
    always_ff @(posedge clock or negedge nReset) begin
        if (!nReset) state <= S_FETCH;
        else         state <= state_next;
    end

    // FSM next state and strobes; strobes only ever asserted in EXEC
    always_comb begin
        state_next = state;
        instr_req  = 1'b0;
        nRAM_RD    = 1'b1;
        nRAM_WR    = 1'b1;
        ram_wdata  = '0;
        exec_done  = 1'b0;
        case (state)
            S_FETCH: begin
                instr_req = 1'b1;
                if (instr_valid) state_next = S_EXEC;
            end
            S_EXEC: begin
                nRAM_WR   = ~is_alu;
                nRAM_RD   = ~is_ld_mem;
                if (is_alu) ram_wdata = alu_result;
                exec_done = ~mem_op | ram_ready;
                if (exec_done) state_next = S_FETCH;
            end
            default: state_next = S_FETCH;
        endcase
    end

    // Datapath: ir captured on fetch, everything else commits at EXEC completion
    always_ff @(posedge clock or negedge nReset) begin
        if (!nReset) begin
            ir    <= '0;
            pc    <= '0;
            carry <= 1'b0;
            for (int i = 0; i < STACK_DEPTH; i++) stack[i] <= '0;
        end else begin
            if (state == S_FETCH && instr_valid) ir <= instruction;
            if (exec_done) begin
                pc <= pc_next;
                if (alu_sets_carry) carry <= alu_full[DATA_W];
                if (push_en) begin
                    for (int i = STACK_DEPTH - 1; i >= 1; i--) stack[i] <= stack[i-1];
                    stack[0] <= push_data;
                end
            end
        end
    end

`ifdef HC4S_ZFLAG_EN
    always_ff @(posedge clock or negedge nReset) begin
        if (!nReset)                zero_flg <= 1'b0;
        else if (exec_done & is_alu) zero_flg <= (alu_result == '0);
    end
`endif

    assign pc_out     = pc;
    assign ram_addr   = ir[3:0];
    assign stackA_out = stack[0];
    assign stackB_out = stack[1];
    assign carry_out  = carry;

endmodule

// File: tb/tb_hc4s_core.sv
// ----------------------------------------------------------------------------
// tb_hc4s_core
//   Directed self-checking bench for hc4s_core (DATA_W=4, STACK_DEPTH=4,
//   PC_W=8). Inputs change and outputs are sampled on the falling clock edge.
//   Expected zero-flag behaviour follows HC4S_ZFLAG_EN as seen by this file.
// ----------------------------------------------------------------------------
module tb_hc4s_core;

    logic       clock = 1'b0;
    logic       nReset;
    logic       instr_req;
    logic       instr_valid;
    logic [7:0] instruction;
    logic [7:0] pc_out;
    logic [3:0] ram_addr;
    logic [3:0] ram_wdata;
    logic [3:0] ram_rdata;
    logic       nRAM_RD;
    logic       nRAM_WR;
    logic       ram_ready;
    logic [3:0] stackA_out;
    logic [3:0] stackB_out;
    logic       carry_out;
    logic       zero_out;

    int n_tests = 0;
    int n_fail  = 0;

    hc4s_core #(.DATA_W(4), .STACK_DEPTH(4), .PC_W(8)) dut (
        .clock       (clock),
        .nReset      (nReset),
        .instr_req   (instr_req),
        .instr_valid (instr_valid),
        .instruction (instruction),
        .pc_out      (pc_out),
        .ram_addr    (ram_addr),
        .ram_wdata   (ram_wdata),
        .ram_rdata   (ram_rdata),
        .nRAM_RD     (nRAM_RD),
        .nRAM_WR     (nRAM_WR),
        .ram_ready   (ram_ready),
        .stackA_out  (stackA_out),
        .stackB_out  (stackB_out),
        .carry_out   (carry_out),
        .zero_out    (zero_out)
    );

    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: observed no finish, expected finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present an opcode in FETCH; returns on the falling edge inside EXEC.
    task automatic fetch(input logic [7:0] op);
        instr_valid = 1'b1;
        instruction = op;
        @(posedge clock);
        @(negedge clock);
    endtask

    // Wait (bounded) for the core to return to FETCH.
    task automatic finish_op();
        int n = 0;
        while (!instr_req && n < 16) begin
            @(negedge clock);
            n++;
        end
        if (n >= 16) begin
            n_tests++;
            n_fail++;
            $error("FAIL finish_timeout: observed instr_req=0 expected 1");
        end
    endtask

    task automatic do_op(input logic [7:0] op);
        fetch(op);
        finish_op();
    endtask

    initial begin
        int rd_low;
        nReset      = 1'b0;
        instr_valid = 1'b0;
        instruction = 8'h00;
        ram_rdata   = 4'h0;
        ram_ready   = 1'b1;
        repeat (2) @(negedge clock);

        // Reset state
        chk("rst_instr_req", 16'(instr_req), 16'h1);
        chk("rst_pc",        16'(pc_out),    16'h0);
        chk("rst_A",         16'(stackA_out),16'h0);
        chk("rst_B",         16'(stackB_out),16'h0);
        chk("rst_carry",     16'(carry_out), 16'h0);
        chk("rst_zero",      16'(zero_out),  16'h0);
        chk("rst_nrd",       16'(nRAM_RD),   16'h1);
        chk("rst_nwr",       16'(nRAM_WR),   16'h1);
        chk("rst_wdata",     16'(ram_wdata), 16'h0);
        nReset = 1'b1;

        // No instruction offered: core waits in FETCH
        repeat (2) @(negedge clock);
        chk("stall_req", 16'(instr_req), 16'h1);
        chk("stall_pc",  16'(pc_out),    16'h0);

        // LD 5, LD 3, ADD -> [2]
        do_op(8'hA5);
        do_op(8'hA3);
        fetch(8'h32);
        chk("add_nwr",   16'(nRAM_WR),   16'h0);
        chk("add_nrd",   16'(nRAM_RD),   16'h1);
        chk("add_addr",  16'(ram_addr),  16'h2);
        chk("add_wdata", 16'(ram_wdata), 16'h8);
        chk("add_req",   16'(instr_req), 16'h0);
        finish_op();
        chk("add_nwr_off", 16'(nRAM_WR),   16'h1);
        chk("add_wdata0",  16'(ram_wdata), 16'h0);
        chk("add_carry",   16'(carry_out), 16'h0);
        chk("add_pc",      16'(pc_out),    16'h3);
        chk("add_A",       16'(stackA_out),16'h3);
        chk("add_B",       16'(stackB_out),16'h5);

        // Push 1..5: bottom overflows
        for (int i = 1; i <= 5; i++) do_op(8'hA0 | 8'(i));
        chk("push_A",  16'(stackA_out), 16'h5);
        chk("push_B",  16'(stackB_out), 16'h4);
        chk("push_pc", 16'(pc_out),     16'h8);

        // 9+9 wraps with carry, then JC to {B,A}=0x04
        do_op(8'hA9);
        do_op(8'hA9);
        fetch(8'h32);
        chk("ovf_wdata", 16'(ram_wdata), 16'h2);
        finish_op();
        chk("ovf_carry", 16'(carry_out), 16'h1);
        chk("ovf_pc",    16'(pc_out),    16'hB);
        do_op(8'hA0);
        do_op(8'hA4);
        chk("jc_A", 16'(stackA_out), 16'h4);
        chk("jc_B", 16'(stackB_out), 16'h0);
        do_op(8'hE2);
        chk("jc_pc", 16'(pc_out), 16'h04);

        // LD [3] with RAM stalling 3 cycles
        ram_ready = 1'b0;
        ram_rdata = 4'hB;
        fetch(8'h83);
        chk("ld_addr", 16'(ram_addr), 16'h3);
        rd_low = 0;
        for (int i = 0; i < 4; i++) begin
            if (nRAM_RD == 1'b0) rd_low++;
            if (i == 1) chk("ld_pc_hold", 16'(pc_out), 16'h04);
            if (i == 2) chk("ld_nwr",     16'(nRAM_WR), 16'h1);
            if (i == 3) ram_ready = 1'b1;
            @(negedge clock);
        end
        chk("ld_rd_cycles", 16'(rd_low),     16'h4);
        chk("ld_nrd_off",   16'(nRAM_RD),    16'h1);
        chk("ld_A",         16'(stackA_out), 16'hB);
        chk("ld_B",         16'(stackB_out), 16'h4);
        chk("ld_pc",        16'(pc_out),     16'h05);

        // NOP, JNC not taken (carry=1), JP to {B,A}=0x4B
        do_op(8'hC0);
        chk("nop_pc", 16'(pc_out), 16'h06);
        do_op(8'hE3);
        chk("jnc_pc", 16'(pc_out), 16'h07);
        do_op(8'hE0);
        chk("jp_pc", 16'(pc_out), 16'h4B);

        // Reset asserted in the middle of a write
        fetch(8'h32);
        chk("mid_nwr",   16'(nRAM_WR),   16'h0);
        chk("mid_wdata", 16'(ram_wdata), 16'hF);
        nReset      = 1'b0;
        instr_valid = 1'b0;
        #1;
        chk("mid_rst_nwr",   16'(nRAM_WR),   16'h1);
        chk("mid_rst_wdata", 16'(ram_wdata), 16'h0);
        chk("mid_rst_pc",    16'(pc_out),    16'h0);
        chk("mid_rst_A",     16'(stackA_out),16'h0);
        chk("mid_rst_B",     16'(stackB_out),16'h0);
        chk("mid_rst_carry", 16'(carry_out), 16'h0);
        @(negedge clock);
        nReset = 1'b1;
        #1;
        chk("mid_rel_req", 16'(instr_req), 16'h1);

        // 7-7 -> zero, no borrow; then JZ to {B,A}=0x09
        do_op(8'hA7);
        do_op(8'hA7);
        fetch(8'h20);
        chk("sub_wdata", 16'(ram_wdata), 16'h0);
        finish_op();
        chk("sub_carry", 16'(carry_out), 16'h1);
`ifdef HC4S_ZFLAG_EN
        chk("sub_zero", 16'(zero_out), 16'h1);
`else
        chk("sub_zero", 16'(zero_out), 16'h0);
`endif
        do_op(8'hA0);
        do_op(8'hA9);
        chk("jz_pre_pc", 16'(pc_out), 16'h05);
        do_op(8'hE4);
`ifdef HC4S_ZFLAG_EN
        chk("jz_pc", 16'(pc_out), 16'h09);
`else
        chk("jz_pc", 16'(pc_out), 16'h06);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
